// File: rtl/button_debounce_sync.sv
// Push-button conditioner: per-channel 2-flop synchronizer, polarity normalize,
// stable-count debounce, and registered press/release strobes aligned to level.

module button_debounce_chan #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int ACTIVE_LOW      = 1,
    parameter int CNT_W           = 19
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic rise_stb,
    output logic fall_stb
);

    localparam logic             IDLE = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic             n;
    logic             st;
    logic             accept;
    logic [CNT_W-1:0] cnt;

    assign n      = (ACTIVE_LOW != 0) ? ~sync2 : sync2;
    assign accept = (n != st) && (cnt == LAST);
    assign level  = st;

    // The counter clears on the accepting edge, so it never exceeds LAST.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1    <= IDLE;
            sync2    <= IDLE;
            cnt      <= '0;
            st       <= 1'b0;
            rise_stb <= 1'b0;
            fall_stb <= 1'b0;
        end else begin
            sync1    <= raw;
            sync2    <= sync1;
            rise_stb <= accept && n;
            fall_stb <= accept && !n;
            if (n == st || accept)
                cnt <= '0;
            else
                cnt <= cnt + CNT_W'(1);
            if (accept)
                st <= n;
        end
    end

endmodule

module button_debounce_sync #(
    parameter int WIDTH           = 2,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int ACTIVE_LOW      = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] btn_raw,
    output logic [WIDTH-1:0] btn_level,
    output logic [WIDTH-1:0] btn_press,
    output logic [WIDTH-1:0] btn_release
);

    localparam int CNT_W = ($clog2(DEBOUNCE_CYCLES) < 1) ? 1 : $clog2(DEBOUNCE_CYCLES);

    for (genvar i = 0; i < WIDTH; i++) begin : g_chan
        button_debounce_chan #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .ACTIVE_LOW     (ACTIVE_LOW),
            .CNT_W          (CNT_W)
        ) u_chan (
            .clk     (clk),
            .reset   (reset),
            .raw     (btn_raw[i]),
            .level   (btn_level[i]),
            .rise_stb(btn_press[i]),
            .fall_stb(btn_release[i])
        );
    end

endmodule

// File: tb/tb_button_debounce_sync.sv
// Bench for button_debounce_sync: directed scenarios with literal checks plus
// randomized hold-time stimulus, all compared every cycle against a run-length model.

module tb_button_debounce_sync;

    localparam int W = 2;
    localparam int D = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] btn_raw;
    logic [W-1:0] btn_level;
    logic [W-1:0] btn_press;
    logic [W-1:0] btn_release;

    int total = 0;
    int bad   = 0;

    button_debounce_sync #(
        .WIDTH          (W),
        .DEBOUNCE_CYCLES(D),
        .ACTIVE_LOW     (1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .btn_raw    (btn_raw),
        .btn_level  (btn_level),
        .btn_press  (btn_press),
        .btn_release(btn_release)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a pin value seen by the design two edges late; a level flips on the
    // D-th consecutive edge on which the pressed-sense differs from it.
    logic [W-1:0] seen1, seen2;
    int           run [W];
    logic [W-1:0] m_lvl, m_press, m_rel;
    bit           mvalid = 0;

    always @(posedge clk) begin
        logic [W-1:0] raw_now;
        logic         pressed;
        raw_now = btn_raw;
        if (reset) begin
            seen1   = '1;
            seen2   = '1;
            m_lvl   = '0;
            m_press = '0;
            m_rel   = '0;
            for (int i = 0; i < W; i++) run[i] = 0;
            mvalid  = 1;
        end else if (mvalid) begin
            for (int i = 0; i < W; i++) begin
                pressed    = !seen2[i];
                m_press[i] = 1'b0;
                m_rel[i]   = 1'b0;
                if (pressed == m_lvl[i]) begin
                    run[i] = 0;
                end else begin
                    run[i] = run[i] + 1;
                    if (run[i] == D) begin
                        m_lvl[i] = pressed;
                        run[i]   = 0;
                        if (pressed) m_press[i] = 1'b1;
                        else         m_rel[i]   = 1'b1;
                    end
                end
            end
            seen2 = seen1;
            seen1 = raw_now;
        end
        #1;
        if (mvalid) begin
            chk("model_level",   btn_level,   m_lvl);
            chk("model_press",   btn_press,   m_press);
            chk("model_release", btn_release, m_rel);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int hold;
        reset   = 1'b1;
        btn_raw = 2'b11;
        cyc(3);
        chk("reset_level",   btn_level,   2'b00);
        chk("reset_press",   btn_press,   2'b00);
        chk("reset_release", btn_release, 2'b00);
        reset = 1'b0;
        cyc(20);
        chk("idle_level", btn_level, 2'b00);
        chk("idle_press", btn_press, 2'b00);

        // Clean press on channel 0: captured on the next edge (E0), level at E0+5.
        btn_raw = 2'b10;
        cyc(5);
        chk("press_before_level", btn_level, 2'b00);
        cyc(1);
        chk("press_level", btn_level, 2'b01);
        chk("press_strobe", btn_press, 2'b01);
        cyc(1);
        chk("press_strobe_off", btn_press, 2'b00);
        chk("press_level_hold", btn_level, 2'b01);
        cyc(5);

        // Release channel 0.
        btn_raw = 2'b11;
        cyc(5);
        chk("release_before", btn_level, 2'b01);
        cyc(1);
        chk("release_level", btn_level, 2'b00);
        chk("release_strobe", btn_release, 2'b01);
        chk("release_no_press", btn_press, 2'b00);
        cyc(1);
        chk("release_strobe_off", btn_release, 2'b00);
        cyc(5);

        // Bounce: low 3, high 1, low 3, high 1, then low steady.
        btn_raw = 2'b10; cyc(3);
        btn_raw = 2'b11; cyc(1);
        btn_raw = 2'b10; cyc(3);
        btn_raw = 2'b11; cyc(1);
        chk("bounce_quiet", btn_level, 2'b00);
        btn_raw = 2'b10;
        cyc(5);
        chk("bounce_before", btn_level, 2'b00);
        chk("bounce_no_strobe", btn_press, 2'b00);
        cyc(1);
        chk("bounce_level", btn_level, 2'b01);
        chk("bounce_press", btn_press, 2'b01);
        btn_raw = 2'b11;
        cyc(10);

        // Simultaneous press on both channels.
        btn_raw = 2'b00;
        cyc(6);
        chk("simul_level", btn_level, 2'b11);
        chk("simul_press", btn_press, 2'b11);
        cyc(1);
        chk("simul_press_off", btn_press, 2'b00);
        btn_raw = 2'b11;
        cyc(10);
        chk("simul_released", btn_level, 2'b00);

        // Reset three edges after capture; button held low throughout.
        btn_raw = 2'b10;
        cyc(3);
        chk("midrst_no_strobe", btn_press, 2'b00);
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        cyc(5);
        chk("midrst_before", btn_level, 2'b00);
        chk("midrst_before_press", btn_press, 2'b00);
        cyc(1);
        chk("midrst_level", btn_level, 2'b01);
        chk("midrst_press", btn_press, 2'b01);
        btn_raw = 2'b11;
        cyc(10);

        // Randomized holds; short holds act as glitches, long ones get accepted.
        for (int s = 0; s < 400; s++) begin
            btn_raw = W'($urandom);
            hold    = (($urandom & 3) == 0) ? int'($urandom_range(6, 12)) : int'($urandom_range(1, 5));
            if ($urandom_range(0, 59) == 0) begin
                reset = 1'b1;
                cyc(1);
                reset = 1'b0;
            end
            cyc(hold);
        end

        cyc(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/button_debounce_sync.md
Name: button_debounce_sync

Overview:
- Conditions raw, asynchronous, bouncing push-button inputs from the board pins into clean, synchronous, active-high levels.
- Its `btn_level` output drives the `in_port` of the processor's Buttons PIO slave, which the Nios processor reads over Avalon.
- It also produces one-cycle press/release strobes for fabric logic that needs edge events without software polling.

Parameters:
- WIDTH, 2, number of button channels; each channel is independent.
- DEBOUNCE_CYCLES, 500000, consecutive stable clk cycles required to accept a new level (10 ms at 50 MHz); legal range ≥ 2.
- ACTIVE_LOW, 1, 1 = raw pin reads 0 when pressed (board KEYs); 0 = raw pin reads 1 when pressed.

Ports:
- clk  input  1  system clock; the only clock.
- reset  input  1  synchronous, active-high reset.
- btn_raw  input  WIDTH  asynchronous raw button pins.
- btn_level  output  WIDTH  debounced level, 1 = pressed; feeds PIO in_port.
- btn_press  output  WIDTH  one-cycle strobe when btn_level goes 0→1.
- btn_release  output  WIDTH  one-cycle strobe when btn_level goes 1→0.

Behaviour:
- Interface:
  - Single clock domain on clk.
  - Reset is synchronous and active-high (`reset`), sampled only on the rising edge of clk.
- Per channel, in order:
  - 2-flop synchronizer (sync1, sync2).
  - Normalize: n = ACTIVE_LOW ? ~sync2 : sync2.
  - Debounce counter cnt, width max(1, clog2(DEBOUNCE_CYCLES)).
  - Registered stable level st, driven out as btn_level.
- Debounce rule, every clk edge when not in reset:
  - n == st: cnt <= 0; st is held. Any bounce back to the current level restarts the count.
  - n != st and cnt != DEBOUNCE_CYCLES-1: cnt <= cnt+1.
  - n != st and cnt == DEBOUNCE_CYCLES-1: st <= n, cnt <= 0, and the matching strobe asserts on this same edge.
- Latency:
  - A raw change first captured by sync1 at edge E0 appears on btn_level at edge E0+DEBOUNCE_CYCLES+1.
  - Condition: n stays at the new value throughout.
- Strobes:
  - btn_press = registered (st rises); btn_release = registered (st falls).
  - Each strobe is high exactly one cycle and aligned with the btn_level transition edge. It never asserts without a btn_level change.
- Counter does not wrap. It is bounded by DEBOUNCE_CYCLES-1 because it clears on the accepting edge.
- Reset values:
  - sync1, sync2 load the inactive raw level: all 1s if ACTIVE_LOW, else 0s.
  - cnt = 0; btn_level = 0; btn_press = 0; btn_release = 0.
- Reset mid-debounce:
  - The count in progress is discarded.
  - After reset releases, a held-pressed button is re-qualified from zero, then produces a normal btn_press.
- Channels:
  - Fully independent.
  - Simultaneous transitions on several channels produce simultaneous strobes on the same edge.
- A glitch shorter than DEBOUNCE_CYCLES produces no change on any output.

Test Plan (DEBOUNCE_CYCLES=4, ACTIVE_LOW=1, WIDTH=2):
- Reset, then btn_raw=2'b11 held for 20 cycles:
  - During and after reset, btn_level=00, btn_press=00, btn_release=00.
- Clean press: btn_raw[0] 1→0 captured at edge E0 and held:
  - btn_level[0]=1 and btn_press[0]=1 at E0+5.
  - btn_press[0]=0 at E0+6.
  - btn_level[1] stays 0 throughout.
- Bounce: btn_raw[0] goes low 3 cycles, high 1, low 3, high 1, then low steady:
  - No output change during the bounce.
  - btn_level[0] rises 5 edges after the final low is captured.
- Release, with channel 0 pressed: btn_raw[0] 0→1 held:
  - btn_level[0]=0 and btn_release[0]=1 for exactly one cycle, 5 edges after capture.
  - btn_press stays 0.
- Simultaneous: both raw bits fall on the same cycle:
  - btn_press=2'b11 on one cycle; btn_level=2'b11 on the same edge.
- Reset mid-debounce: btn_raw[0]=0, reset asserted for 1 cycle 3 edges after capture, btn_raw held low:
  - No strobe before reset.
  - btn_press[0] and btn_level[0] rise at the 6th edge after reset deasserts (2 sync + 4 count), counted from the first post-reset edge.
